// File: rtl/spi_cmd_ctrl_if.sv
// spi_cmd_ctrl_if: register-bus connection between the SPI command
// controller (master) and the register file (slave).
// Handshake: the master raises bus_req with bus_we/bus_addr/bus_wdata stable
// and holds them until the slave answers with a one-cycle bus_ack. On a read,
// bus_rdata is valid in the cycle bus_ack is high.
interface spi_cmd_ctrl_if #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 32
) ();
  logic              bus_req;
  logic              bus_we;
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_wdata;
  logic [DATA_W-1:0] bus_rdata;
  logic              bus_ack;

  modport master (
    output bus_req, bus_we, bus_addr, bus_wdata,
    input  bus_rdata, bus_ack
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_wdata,
    output bus_rdata, bus_ack
  );
endinterface

// File: rtl/spi_cmd_ctrl.sv
// spi_cmd_ctrl: turns SPI frames (one 8-bit command word followed by data
// words) into register-bus reads and writes with auto-incrementing address.
// Optional feature macro: SPI_CMD_CTRL_TIMEOUT_EN adds a bus-ack timeout of
// BUS_TIMEOUT cycles; without it err_timeout is tied low and the wait for
// bus_ack is unbounded.
// state_dbg exposes the FSM state encoding for observation.
module spi_cmd_ctrl #(
  parameter int ADDR_W      = 7,
  parameter int DATA_W      = 32,
  parameter int BUS_TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              frame_active,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_valid,
  output logic [DATA_W-1:0] tx_data,
  output logic [5:0]        cfg_data_width,
  output logic              busy,
  output logic              err_overrun,
  output logic              err_timeout,
  output logic [2:0]        state_dbg,
  spi_cmd_ctrl_if.master    bus
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CMD     = 3'd1,
    S_WR_WAIT = 3'd2,
    S_WR_BUS  = 3'd3,
    S_RD_BUS  = 3'd4,
    S_RD_WAIT = 3'd5
  } state_t;

  state_t            state_q, state_d;
  logic              frame_prev_q;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] tx_q, tx_d;
  logic              ovr_q, ovr_d;

  logic              in_bus;
  logic              frame_start;
  logic              bus_tmo;
  logic              bus_done;
  logic              req;
  logic              we;

  assign in_bus      = (state_q == S_WR_BUS) || (state_q == S_RD_BUS);
  assign frame_start = (state_q == S_IDLE) && frame_active && !frame_prev_q;
  // A timed-out access is finished exactly as if it had been acknowledged.
  assign bus_done    = bus.bus_ack || bus_tmo;

`ifdef SPI_CMD_CTRL_TIMEOUT_EN
  localparam int TMO_W = $clog2(BUS_TIMEOUT + 1);

  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic             tmo_err_q, tmo_err_d;

  // Count cycles spent waiting for bus_ack; fire on the last allowed cycle.
  always_comb begin
    tmo_cnt_d = '0;
    tmo_err_d = tmo_err_q;
    bus_tmo   = 1'b0;
    if (in_bus) begin
      if (!bus.bus_ack && (tmo_cnt_q == TMO_W'(BUS_TIMEOUT - 1))) begin
        bus_tmo   = 1'b1;
        tmo_err_d = 1'b1;
      end else begin
        tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
      end
    end
    if (frame_start) begin
      tmo_err_d = 1'b0;
    end
  end

  // Timeout counter and sticky timeout flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt_q <= '0;
      tmo_err_q <= 1'b0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
      tmo_err_q <= tmo_err_d;
    end
  end

  assign err_timeout = tmo_err_q;
`else
  logic unused_bus_timeout;
  assign unused_bus_timeout = ^BUS_TIMEOUT;
  assign bus_tmo            = 1'b0;
  assign err_timeout        = 1'b0;
`endif

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      frame_prev_q <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      tx_q         <= '0;
      ovr_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      frame_prev_q <= frame_active;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      tx_q         <= tx_d;
      ovr_q        <= ovr_d;
    end
  end

  // Next state and datapath updates. An rx_valid always wins over a
  // simultaneous frame end so the last word of a frame is not lost.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    tx_d    = tx_q;
    ovr_d   = ovr_q;
    case (state_q)
      S_IDLE: begin
        tx_d = '0;
        if (frame_start) begin
          state_d = S_CMD;
          ovr_d   = 1'b0;
        end
      end
      S_CMD: begin
        if (rx_valid) begin
          addr_d  = rx_data[ADDR_W-1:0];
          state_d = rx_data[7] ? S_RD_BUS : S_WR_WAIT;
        end else if (!frame_active) begin
          state_d = S_IDLE;
        end
      end
      S_WR_WAIT: begin
        if (rx_valid) begin
          wdata_d = rx_data;
          state_d = S_WR_BUS;
        end else if (!frame_active) begin
          state_d = S_IDLE;
        end
      end
      S_WR_BUS: begin
        if (rx_valid) begin
          ovr_d = 1'b1;
        end
        if (bus_done) begin
          addr_d  = addr_q + ADDR_W'(1);
          state_d = frame_active ? S_WR_WAIT : S_IDLE;
        end
      end
      S_RD_BUS: begin
        if (rx_valid) begin
          ovr_d = 1'b1;
        end
        if (bus_done) begin
          tx_d    = bus.bus_ack ? bus.bus_rdata : '1;
          state_d = frame_active ? S_RD_WAIT : S_IDLE;
        end
      end
      S_RD_WAIT: begin
        if (rx_valid) begin
          addr_d  = addr_q + ADDR_W'(1);
          state_d = S_RD_BUS;
        end else if (!frame_active) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs decoded from the current state.
  always_comb begin
    req            = 1'b0;
    we             = 1'b0;
    cfg_data_width = 6'(DATA_W);
    case (state_q)
      S_IDLE, S_CMD: cfg_data_width = 6'd8;
      S_WR_BUS: begin
        req = 1'b1;
        we  = 1'b1;
      end
      S_RD_BUS: req = 1'b1;
      default: ;
    endcase
  end

  assign busy          = (state_q != S_IDLE);
  assign err_overrun   = ovr_q;
  assign tx_data       = tx_q;
  assign state_dbg     = state_q;
  assign bus.bus_req   = req;
  assign bus.bus_we    = we;
  assign bus.bus_addr  = addr_q;
  assign bus.bus_wdata = wdata_q;

endmodule

// File: tb/tb_spi_cmd_ctrl.sv
// tb_spi_cmd_ctrl: drives SPI frames into spi_cmd_ctrl, answers the register
// bus with a model slave and compares every bus access against expectations
// queued when the corresponding SPI word was driven.
module tb_spi_cmd_ctrl;
  localparam int ADDR_W      = 7;
  localparam int DATA_W      = 32;
  localparam int BUS_TIMEOUT = 16;
  localparam int W           = 1 + ADDR_W + DATA_W;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              frame_active = 1'b0;
  logic [DATA_W-1:0] rx_data = '0;
  logic              rx_valid = 1'b0;
  logic [DATA_W-1:0] tx_data;
  logic [5:0]        cfg_data_width;
  logic              busy;
  logic              err_overrun;
  logic              err_timeout;
  logic [2:0]        state_dbg;

  spi_cmd_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus_if ();

  spi_cmd_ctrl #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BUS_TIMEOUT(BUS_TIMEOUT)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .frame_active(frame_active),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .tx_data(tx_data),
    .cfg_data_width(cfg_data_width),
    .busy(busy),
    .err_overrun(err_overrun),
    .err_timeout(err_timeout),
    .state_dbg(state_dbg),
    .bus(bus_if)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [W-1:0]      exp_q[$];   // {we, addr, wdata-or-rdata}
  logic [DATA_W-1:0] words[8];
  int ack_delay = 0;
  bit ack_hold  = 1'b0;
  int n_bus     = 0;

  task automatic check(input string tag, input logic [DATA_W-1:0] got,
                       input logic [DATA_W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] mk(input bit we, input int a,
                                      input logic [DATA_W-1:0] d);
    return {we, ADDR_W'(a), d};
  endfunction

  // ---------------- register-bus slave model ----------------
  initial begin : responder
    int wait_cnt;
    bit tx_pend;
    logic [DATA_W-1:0] tx_exp;
    logic [W-1:0] e;
    wait_cnt = 0;
    tx_pend  = 1'b0;
    tx_exp   = '0;
    bus_if.bus_ack   = 1'b0;
    bus_if.bus_rdata = '0;
    forever begin
      @(posedge clk); #1;
      bus_if.bus_ack = 1'b0;
      if (tx_pend) begin
        tx_pend = 1'b0;
        check("tx_data_after_read", tx_data, tx_exp);
      end
      if (rst_n && bus_if.bus_req && !ack_hold) begin
        if (wait_cnt < ack_delay) begin
          wait_cnt++;
        end else begin
          wait_cnt = 0;
          n_bus++;
          if (exp_q.size() == 0) begin
            check("bus_unexpected", DATA_W'(bus_if.bus_req), '0);
          end else begin
            e = exp_q.pop_front();
            check("bus_we", DATA_W'(bus_if.bus_we), DATA_W'(e[W-1]));
            check("bus_addr", DATA_W'(bus_if.bus_addr), DATA_W'(e[W-2 -: ADDR_W]));
            if (e[W-1]) begin
              check("bus_wdata", bus_if.bus_wdata, e[DATA_W-1:0]);
            end else begin
              bus_if.bus_rdata = e[DATA_W-1:0];
              tx_exp  = e[DATA_W-1:0];
              tx_pend = 1'b1;
            end
          end
          bus_if.bus_ack = 1'b1;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic send_word(input logic [DATA_W-1:0] w);
    rx_data  = w;
    rx_valid = 1'b1;
    tick(1);
    rx_valid = 1'b0;
  endtask

  function automatic logic [DATA_W-1:0] cmd_word(input bit rd, input int a);
    logic [DATA_W-1:0] c;
    c = '0;
    c[7] = rd;
    c[ADDR_W-1:0] = ADDR_W'(a);
    return c;
  endfunction

  task automatic frame_begin();
    frame_active = 1'b1;
    tick(1);
    check("busy_in_cmd", DATA_W'(busy), 1);
    check("cfg_width_cmd", DATA_W'(cfg_data_width), 8);
  endtask

  task automatic frame_end();
    frame_active = 1'b0;
    tick(2);
    check("busy_after_frame", DATA_W'(busy), 0);
    check("cfg_width_idle", DATA_W'(cfg_data_width), 8);
    check("tx_data_idle", tx_data, '0);
  endtask

  // Write frame: words[0..n-1] to consecutive addresses from a.
  task automatic write_frame(input int a, input int n);
    int n0;
    n0 = n_bus;
    frame_begin();
    send_word(cmd_word(1'b0, a));
    check("cfg_width_data", DATA_W'(cfg_data_width), DATA_W);
    for (int i = 0; i < n; i++) begin
      if (i > 0) tick(ack_delay + 3 + $urandom_range(0, 2));
      exp_q.push_back(mk(1'b1, a + i, words[i]));
      send_word(words[i]);
    end
    tick(ack_delay + 4);
    frame_end();
    check("write_count", DATA_W'(n_bus - n0), DATA_W'(n));
  endtask

  // Read frame: slave returns words[0..n-1] from consecutive addresses from a.
  task automatic read_frame(input int a, input int n);
    int n0;
    n0 = n_bus;
    frame_begin();
    exp_q.push_back(mk(1'b0, a, words[0]));
    send_word(cmd_word(1'b1, a));
    check("cfg_width_data", DATA_W'(cfg_data_width), DATA_W);
    for (int i = 1; i < n; i++) begin
      tick(ack_delay + 3 + $urandom_range(0, 2));
      exp_q.push_back(mk(1'b0, a + i, words[i]));
      send_word(DATA_W'($urandom));
    end
    tick(ack_delay + 4);
    frame_end();
    check("read_count", DATA_W'(n_bus - n0), DATA_W'(n));
  endtask

  // ---------------- test sequence ----------------
  initial begin : main
    int n0;
    int cnt;
    tick(3);
    check("rst_busy", DATA_W'(busy), 0);
    check("rst_bus_req", DATA_W'(bus_if.bus_req), 0);
    check("rst_bus_we", DATA_W'(bus_if.bus_we), 0);
    check("rst_bus_addr", DATA_W'(bus_if.bus_addr), 0);
    check("rst_bus_wdata", bus_if.bus_wdata, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_cfg_width", DATA_W'(cfg_data_width), 8);
    check("rst_err_overrun", DATA_W'(err_overrun), 0);
    check("rst_err_timeout", DATA_W'(err_timeout), 0);
    rst_n = 1'b1;
    tick(2);

    // Directed write frame at 0x05.
    ack_delay = 1;
    words[0] = 32'h11223344;
    words[1] = 32'hAABBCCDD;
    write_frame(5, 2);

    // Directed read frame with address wrap 0x7F -> 0x00.
    ack_delay = 2;
    words[0] = 32'hCAFE0001;
    words[1] = 32'hCAFE0002;
    read_frame(127, 2);

    // Random frames.
    for (int k = 0; k < 6; k++) begin
      ack_delay = $urandom_range(0, 3);
      for (int i = 0; i < 8; i++) words[i] = DATA_W'($urandom);
      if (k % 2 == 0) write_frame($urandom_range(0, 127), $urandom_range(1, 4));
      else            read_frame($urandom_range(120, 127), $urandom_range(1, 5));
    end

    // Overrun: second word arrives while the first write awaits a slow ack.
    ack_delay = 10;
    n0 = n_bus;
    frame_begin();
    send_word(cmd_word(1'b0, 16));
    exp_q.push_back(mk(1'b1, 16, 32'h0BAD0001));
    send_word(32'h0BAD0001);
    tick(3);
    send_word(32'h0BAD0002);
    check("overrun_set", DATA_W'(err_overrun), 1);
    tick(12);
    check("overrun_one_write", DATA_W'(n_bus - n0), 1);
    frame_end();
    check("overrun_sticky", DATA_W'(err_overrun), 1);
    frame_begin();
    check("overrun_cleared", DATA_W'(err_overrun), 0);
    frame_end();

    // Frame ends during a read that is acked later.
    ack_delay = 4;
    n0 = n_bus;
    frame_begin();
    exp_q.push_back(mk(1'b0, 34, 32'h5EED0022));
    send_word(cmd_word(1'b1, 34));
    frame_active = 1'b0;
    tick(1);
    check("late_ack_req_held", DATA_W'(bus_if.bus_req), 1);
    check("late_ack_busy", DATA_W'(busy), 1);
    tick(2);
    check("late_ack_req_held2", DATA_W'(bus_if.bus_req), 1);
    tick(3);
    check("late_ack_idle_busy", DATA_W'(busy), 0);
    check("late_ack_idle_req", DATA_W'(bus_if.bus_req), 0);
    check("late_ack_reads", DATA_W'(n_bus - n0), 1);

    // Ack never arrives.
    ack_delay = 0;
    ack_hold  = 1'b1;
    frame_begin();
    send_word(cmd_word(1'b1, 64));
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (!bus_if.bus_req) break;
      cnt++;
      tick(1);
    end
`ifdef SPI_CMD_CTRL_TIMEOUT_EN
    check("tmo_req_cycles", DATA_W'(cnt), BUS_TIMEOUT);
    check("tmo_err_set", DATA_W'(err_timeout), 1);
    check("tmo_tx_ones", tx_data, '1);
    ack_hold = 1'b0;
    frame_end();
    frame_begin();
    check("tmo_err_cleared", DATA_W'(err_timeout), 0);
    frame_end();
`else
    check("no_tmo_req_cycles", DATA_W'(cnt), 40);
    check("no_tmo_err", DATA_W'(err_timeout), 0);
    exp_q.push_back(mk(1'b0, 64, 32'h0D0D0040));
    ack_hold = 1'b0;
    tick(3);
    frame_end();
`endif

    // Reset in the middle of a bus access drops bus_req at once.
    ack_hold = 1'b1;
    frame_begin();
    send_word(cmd_word(1'b0, 3));
    send_word(32'h77778888);
    check("mid_rst_req_before", DATA_W'(bus_if.bus_req), 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_req_dropped", DATA_W'(bus_if.bus_req), 0);
    check("mid_rst_busy", DATA_W'(busy), 0);
    check("mid_rst_addr", DATA_W'(bus_if.bus_addr), 0);
    frame_active = 1'b0;
    tick(2);
    rst_n    = 1'b1;
    ack_hold = 1'b0;
    tick(2);

    check("exp_q_drained", DATA_W'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
